lsu_ctrl: RTL and testbench

- Core-side load/store initiator for the RV32I datapath; the requesting end of the data-memory interface.
- Accepts one load/store per handshake from the execute stage and checks alignment and funct3 legality.
- Drives a word-addressed memory bus with byte enables and lane-replicated write data, then waits for the response.
- Extracts and sign/zero-extends load data, returns it to writeback with a done pulse and error code.

---
 rtl/lsu_ctrl_if.sv | 25 ++
 rtl/lsu_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Word-addressed data-memory bus between the load/store unit (master) and memory (slave).
// Requests are held until gnt; the response comes back on rvalid/rdata.
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic                  we;
    logic [3:0]            be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store initiator: checks legality, runs one bus transaction at a
// time with a REQ+WAIT timeout, and returns extended load data with an error code.
module lsu_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_valid_i,
    output logic                  core_ready_o,
    input  logic                  core_we_i,
    input  logic [2:0]            core_funct3_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic                  core_done_o,
    output logic [1:0]            core_err_o,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    lsu_ctrl_if.master            mem
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_e;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            2'b01:   m = a[0];
            2'b10:   m = a[1] | a[0];
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] size,
                                                         input logic [DATA_WIDTH-1:0] wd);
        logic [DATA_WIDTH-1:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                                        input logic [DATA_WIDTH-1:0] word);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (a)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Next-state, bus and completion logic; every entry into RESP loads done/err/rdata.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        done_d      = 1'b0;
        err_d       = ERR_OK;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (core_valid_i) begin
                    we_d      = core_we_i;
                    funct3_d  = core_funct3_i;
                    addr_lo_d = core_addr_i[1:0];
                    cnt_d     = '0;
                    if (!funct3_legal(core_we_i, core_funct3_i)) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = ERR_FUNCT3;
                        rdata_d = '0;
                    end else if (misaligned(core_funct3_i[1:0], core_addr_i[1:0])) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = ERR_MISALIGN;
                        rdata_d = '0;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = core_we_i;
                        mem_be_d    = byte_en(core_funct3_i[1:0], core_addr_i[1:0]);
                        mem_addr_d  = {core_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = store_data(core_funct3_i[1:0], core_wdata_i);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.gnt) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = ERR_TIMEOUT;
                    rdata_d   = '0;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.rvalid) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                    rdata_d = we_q ? '0 : load_data(funct3_q, addr_lo_q, mem.rdata);
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign core_ready_o = ready_q;
    assign core_done_o  = done_q;
    assign core_err_o   = err_q;
    assign core_rdata_o = rdata_q;
    assign mem.req      = mem_req_q;
    assign mem.we       = mem_we_q;
    assign mem.be       = mem_be_q;
    assign mem.addr     = mem_addr_q;
    assign mem.wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected completions are queued when a request is
// driven and popped when core_done appears; inputs driven and outputs sampled on negedge.
module tb_lsu_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid;
    logic        core_ready;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_done;
    logic [1:0]  core_err;
    logic [31:0] core_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
        bit          chk_rd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    lsu_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_valid_i (core_valid),
        .core_ready_o (core_ready),
        .core_we_i    (core_we),
        .core_funct3_i(core_funct3),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_done_o  (core_done),
        .core_err_o   (core_err),
        .core_rdata_o (core_rdata),
        .mem          (mem_bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request from the core side plus the memory-side response; bus=0 means no bus activity expected.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rword,
                       input int gnt_dly, input bit give_rv, input bit bus,
                       input logic [3:0] xbe, input logic [31:0] xaddr, input logic [31:0] xwdata,
                       input logic [1:0] xerr, input logic [31:0] xrdata, input bit chk_rd, input int xlat);
        exp_t e;
        int   lat;
        e.err = xerr; e.rdata = xrdata; e.chk_rd = chk_rd; e.lat = xlat;
        sb.push_back(e);
        chk({tag, ".ready"}, 32'(core_ready), 32'd1);
        core_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
        @(negedge clk);
        core_valid = 1'b0; core_addr = $urandom(); core_wdata = $urandom();
        lat = 1;
        if (bus) begin
            for (int i = 0; i <= gnt_dly; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    lat++;
                end
                chk({tag, ".mem_req"}, 32'(mem_bus.req), 32'd1);
                chk({tag, ".mem_we"}, 32'(mem_bus.we), 32'(we));
                chk({tag, ".mem_be"}, 32'(mem_bus.be), 32'(xbe));
                chk({tag, ".mem_addr"}, mem_bus.addr, xaddr);
                if (we) chk({tag, ".mem_wdata"}, mem_bus.wdata, xwdata);
                if (i == gnt_dly) mem_bus.gnt = 1'b1;
            end
            @(negedge clk);
            lat++;
            mem_bus.gnt = 1'b0;
            chk({tag, ".req_drop"}, 32'(mem_bus.req), 32'd0);
            if (give_rv) begin
                mem_bus.rvalid = 1'b1; mem_bus.rdata = rword;
                @(negedge clk);
                lat++;
                mem_bus.rvalid = 1'b0; mem_bus.rdata = $urandom();
            end
        end else begin
            chk({tag, ".no_req"}, 32'(mem_bus.req), 32'd0);
        end
        for (int n = 0; n < 64 && core_done !== 1'b1; n++) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".done"}, 32'(core_done), 32'd1);
        chk({tag, ".err"}, 32'(core_err), 32'(e.err));
        if (e.chk_rd) chk({tag, ".rdata"}, core_rdata, e.rdata);
        chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(core_done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; core_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
        core_addr = 32'h0; core_wdata = 32'h0;
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(core_ready), 32'd1);
        chk("rst.done", 32'(core_done), 32'd0);
        chk("rst.err", 32'(core_err), 32'd0);
        chk("rst.rdata", core_rdata, 32'd0);
        chk("rst.mem_req", 32'(mem_bus.req), 32'd0);
        chk("rst.mem_we", 32'(mem_bus.we), 32'd0);
        chk("rst.mem_be", 32'(mem_bus.be), 32'd0);
        chk("rst.mem_addr", mem_bus.addr, 32'd0);
        chk("rst.mem_wdata", mem_bus.wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Byte load from top lane, sign-extended.
        txn("lb_0x13", 1'b0, 3'b000, 32'h0000_0013, 32'h0, 32'h80FF_7F01, 0, 1'b1, 1'b1,
            4'b1000, 32'h0000_0010, 32'h0, 2'b00, 32'hFFFF_FF80, 1'b1, 3);
        txn("lb_0x01", 1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'h80FF_7F01, 0, 1'b1, 1'b1,
            4'b0010, 32'h0000_0000, 32'h0, 2'b00, 32'h0000_007F, 1'b1, 3);
        // Stores: half, byte, word.
        txn("sh_0x22", 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'h5A5A_5A5A, 0, 1'b1, 1'b1,
            4'b1100, 32'h0000_0020, 32'hABCD_ABCD, 2'b00, 32'h0, 1'b1, 3);
        txn("sb_0x03", 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 1'b1, 1'b1,
            4'b1000, 32'h0000_0100, 32'hA5A5_A5A5, 2'b00, 32'h0, 1'b1, 3);
        txn("sw_0x04", 1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 0, 1'b1, 1'b1,
            4'b1111, 32'h0000_0004, 32'hCAFE_F00D, 2'b00, 32'h0, 1'b1, 3);
        // Half/byte extension variants.
        txn("lhu_0x2", 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_F00F, 0, 1'b1, 1'b1,
            4'b1100, 32'h0000_0000, 32'h0, 2'b00, 32'h0000_8001, 1'b1, 3);
        txn("lh_0x2", 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_F00F, 0, 1'b1, 1'b1,
            4'b1100, 32'h0000_0000, 32'h0, 2'b00, 32'hFFFF_8001, 1'b1, 3);
        txn("lbu_0x0", 1'b0, 3'b100, 32'h0000_0000, 32'h0, 32'h8001_F00F, 0, 1'b1, 1'b1,
            4'b0001, 32'h0000_0000, 32'h0, 2'b00, 32'h0000_000F, 1'b1, 3);
        // Error paths: no bus activity, done one cycle after accept.
        txn("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b0, 1'b0,
            4'b0000, 32'h0, 32'h0, 2'b01, 32'h0, 1'b0, 1);
        txn("sh_mis", 1'b1, 3'b001, 32'h0000_0001, 32'h1111_2222, 32'h0, 0, 1'b0, 1'b0,
            4'b0000, 32'h0, 32'h0, 2'b01, 32'h0, 1'b0, 1);
        txn("st_f3_100", 1'b1, 3'b100, 32'h0000_0008, 32'h3333_4444, 32'h0, 0, 1'b0, 1'b0,
            4'b0000, 32'h0, 32'h0, 2'b10, 32'h0, 1'b0, 1);
        // Grant withheld, then no rvalid: times out after TIMEOUT cycles in REQ+WAIT.
        txn("timeout", 1'b0, 3'b001, 32'h0000_0046, 32'h0, 32'h0, 3, 1'b0, 1'b1,
            4'b1100, 32'h0000_0044, 32'h0, 2'b11, 32'h0, 1'b1, TIMEOUT + 1);
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h1234_5678;
        @(negedge clk);
        mem_bus.rvalid = 1'b0;
        chk("late_rv.done", 32'(core_done), 32'd0);
        @(negedge clk);
        chk("late_rv.done2", 32'(core_done), 32'd0);
        chk("late_rv.ready", 32'(core_ready), 32'd1);

        // Reset while waiting for rvalid abandons the transaction.
        core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h0000_0008;
        @(negedge clk);
        core_valid = 1'b0;
        chk("rstmid.req", 32'(mem_bus.req), 32'd1);
        mem_bus.gnt = 1'b1;
        @(negedge clk);
        mem_bus.gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hDEAD_0000;
        chk("rstmid.done", 32'(core_done), 32'd0);
        chk("rstmid.mem_req", 32'(mem_bus.req), 32'd0);
        chk("rstmid.ready", 32'(core_ready), 32'd1);
        @(negedge clk);
        mem_bus.rvalid = 1'b0;
        chk("rstmid.no_done", 32'(core_done), 32'd0);
        @(negedge clk);
        chk("rstmid.no_done2", 32'(core_done), 32'd0);
        txn("lw_after_rst", 1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b1,
            4'b1111, 32'h0000_0004, 32'h0, 2'b00, 32'hDEAD_BEEF, 1'b1, 3);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
